// File: rtl/winner_scan_nxn_pkg.sv
// winner_scan_nxn_pkg: cell codes, FSM states and scan directions for the board engine.
// Revision 1.0
`default_nettype none
package winner_scan_nxn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SCAN  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] DIR_ROW  = 2'd0;
  localparam logic [1:0] DIR_COL  = 2'd1;
  localparam logic [1:0] DIR_DIAG = 2'd2;
  localparam logic [1:0] DIR_ANTI = 2'd3;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_X) ? CELL_O : CELL_X;
  endfunction

endpackage
`default_nettype wire

// File: rtl/winner_scan_nxn_line_walker.sv
// winner_scan_nxn_line_walker: maps (row, col, direction, offset) to an on-board flag and flat cell index.
// Revision 1.0
`default_nettype none
module winner_scan_nxn_line_walker
  import winner_scan_nxn_pkg::*;
#(
  parameter int N  = 4,
  parameter int RW = $clog2(N),
  parameter int CW = RW + 2,
  parameter int IW = $clog2(N * N)
) (
  input  logic [RW-1:0]        i_row,
  input  logic [RW-1:0]        i_col,
  input  logic [1:0]           i_dir,
  input  logic signed [CW-1:0] i_off,
  output logic                 o_on_board,
  output logic [IW-1:0]        o_idx
);

  localparam logic signed [CW-1:0] C_N    = CW'(N);
  localparam logic signed [CW-1:0] C_ZERO = '0;

  logic signed [CW-1:0] w_r;
  logic signed [CW-1:0] w_c;

  always_comb begin
    w_r = $signed({2'b00, i_row});
    w_c = $signed({2'b00, i_col});
    unique case (i_dir)
      DIR_ROW:  w_c = w_c + i_off;
      DIR_COL:  w_r = w_r + i_off;
      DIR_DIAG: begin
        w_r = w_r + i_off;
        w_c = w_c + i_off;
      end
      default: begin
        w_r = w_r + i_off;
        w_c = w_c - i_off;
      end
    endcase
    o_on_board = (w_r >= C_ZERO) && (w_r < C_N) && (w_c >= C_ZERO) && (w_c < C_N);
    // Index is only meaningful when on-board; the caller pads the board so any value is safe.
    o_idx = IW'(int'(w_r) * N + int'(w_c));
  end

endmodule
`default_nettype wire

// File: rtl/winner_scan_nxn.sv
// winner_scan_nxn: N x N K-in-a-row board engine; walks the 4 lines through each move at fixed latency.
// Revision 1.0
`default_nettype none
module winner_scan_nxn
  import winner_scan_nxn_pkg::*;
#(
  parameter int N            = 4,
  parameter int K            = 4,
  parameter int ENFORCE_TURN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_move_valid,
  output logic                   o_move_ready,
  input  logic [$clog2(N)-1:0]   i_move_row,
  input  logic [$clog2(N)-1:0]   i_move_col,
  input  logic [1:0]             i_move_who,
  output logic                   o_result_valid,
  output logic                   o_win,
  output logic [1:0]             o_who,
  output logic                   o_draw,
  output logic                   o_illegal,
  output logic                   o_game_over,
  output logic [2*N*N-1:0]       o_board
);

  localparam int RW    = $clog2(N);
  localparam int CW    = RW + 2;
  localparam int IW    = $clog2(N * N);
  localparam int NCELL = N * N;
  localparam int NPAD  = 1 << IW;
  localparam int RUNW  = $clog2(K + 1);
  localparam int CNTW  = $clog2(N * N + 1);

  localparam logic signed [CW-1:0] C_OFF_LO  = CW'(-(K - 1));
  localparam logic signed [CW-1:0] C_OFF_HI  = CW'(K - 1);
  localparam logic signed [CW-1:0] C_OFF_ONE = CW'(1);
  localparam logic [RUNW-1:0]      C_K       = RUNW'(K);
  localparam logic [RUNW-1:0]      C_KM1     = RUNW'(K - 1);
  localparam logic [CNTW-1:0]      C_FULL    = CNTW'(NCELL);

  state_t               r_state;
  state_t               w_next;
  logic [2*NCELL-1:0]   r_board;
  logic [RW-1:0]        r_row;
  logic [RW-1:0]        r_col;
  logic [1:0]           r_who;
  logic [1:0]           r_turn;
  logic [1:0]           r_dir;
  logic signed [CW-1:0] r_off;
  logic [RUNW-1:0]      r_run;
  logic                 r_hit;
  logic                 r_pend_illegal;
  logic [CNTW-1:0]      r_cnt;
  logic                 r_win;
  logic [1:0]           r_win_who;
  logic                 r_draw;
  logic                 r_illegal;
  logic                 r_result_valid;

  logic [2*NPAD-1:0]    w_board_ext;
  logic                 w_accept;
  logic                 w_on;
  logic [IW-1:0]        w_idx;
  logic [IW-1:0]        w_chk_idx;
  logic [1:0]           w_cell;
  logic [1:0]           w_chk_cell;
  logic                 w_illegal;
  logic                 w_match;
  logic                 w_last_off;
  logic                 w_last_step;

  winner_scan_nxn_line_walker #(.N(N)) u_walker (
    .i_row      (r_row),
    .i_col      (r_col),
    .i_dir      (r_dir),
    .i_off      (r_off),
    .o_on_board (w_on),
    .o_idx      (w_idx)
  );

  // Board padded to a power-of-two cell count so any computed index stays in range.
  assign w_board_ext = (2*NPAD)'(r_board);
  assign w_chk_idx   = IW'(int'(r_row) * N + int'(r_col));
  assign w_cell      = w_board_ext[2*w_idx +: 2];
  assign w_chk_cell  = w_board_ext[2*w_chk_idx +: 2];
  assign w_accept    = i_move_valid && (r_state == ST_IDLE) && !i_clear;
  assign w_match     = (r_state == ST_SCAN) && w_on && (w_cell == r_who);
  assign w_last_off  = (r_off == C_OFF_HI);
  assign w_last_step = w_last_off && (r_dir == DIR_ANTI);

  assign w_illegal = (int'(r_row) >= N) || (int'(r_col) >= N) ||
                     (w_chk_cell != CELL_EMPTY) ||
                     (r_who == CELL_EMPTY) || (r_who == 2'b11) ||
                     o_game_over ||
                     ((ENFORCE_TURN != 0) && (r_who != r_turn));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_CHECK;
      ST_CHECK: w_next = w_illegal ? ST_PAD : ST_SCAN;
      ST_SCAN,
      ST_PAD:   if (w_last_step) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (i_clear) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board <= '0; r_row <= '0; r_col <= '0; r_who <= CELL_EMPTY;
      r_turn <= CELL_X; r_dir <= DIR_ROW; r_off <= C_OFF_LO; r_run <= '0;
      r_hit <= 1'b0; r_pend_illegal <= 1'b0; r_cnt <= '0; r_win <= 1'b0;
      r_win_who <= CELL_EMPTY; r_draw <= 1'b0; r_illegal <= 1'b0; r_result_valid <= 1'b0;
    end else if (i_clear) begin
      r_board <= '0; r_row <= '0; r_col <= '0; r_who <= CELL_EMPTY;
      r_turn <= CELL_X; r_dir <= DIR_ROW; r_off <= C_OFF_LO; r_run <= '0;
      r_hit <= 1'b0; r_pend_illegal <= 1'b0; r_cnt <= '0; r_win <= 1'b0;
      r_win_who <= CELL_EMPTY; r_draw <= 1'b0; r_illegal <= 1'b0; r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_row <= i_move_row;
            r_col <= i_move_col;
            r_who <= i_move_who;
          end
        end
        ST_CHECK: begin
          r_pend_illegal <= w_illegal;
          r_dir          <= DIR_ROW;
          r_off          <= C_OFF_LO;
          r_run          <= '0;
          r_hit          <= 1'b0;
          if (!w_illegal) begin
            r_board[2*w_chk_idx +: 2] <= r_who;
            r_cnt                     <= r_cnt + CNTW'(1);
            r_turn                    <= other_player(r_turn);
          end
        end
        ST_SCAN, ST_PAD: begin
          if (w_match && (r_run == C_KM1)) r_hit <= 1'b1;
          if (w_last_off) begin
            r_off <= C_OFF_LO;
            r_dir <= r_dir + 2'd1;
            r_run <= '0;
          end else begin
            r_off <= r_off + C_OFF_ONE;
            if (!w_match)          r_run <= '0;
            else if (r_run != C_K) r_run <= r_run + RUNW'(1);
          end
        end
        ST_DONE: begin
          r_result_valid <= 1'b1;
          r_illegal      <= r_pend_illegal;
          if (!r_pend_illegal) begin
            if (r_hit) begin
              r_win     <= 1'b1;
              r_win_who <= r_who;
            end else if (r_cnt == C_FULL) begin
              r_draw <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_move_ready   = (r_state == ST_IDLE);
  assign o_result_valid = r_result_valid;
  assign o_win          = r_win;
  assign o_who          = r_win_who;
  assign o_draw         = r_draw;
  assign o_illegal      = r_illegal;
  assign o_game_over    = r_win | r_draw;
  assign o_board        = r_board;

endmodule
`default_nettype wire
